inject_ctrl: RTL and testbench
==============================

INJECT_CTRL -- requirements
Module: inject_ctrl

Interface
REQ-001 FIFO_DEPTH, default 4, injection FIFO depth in flits; power of two, minimum 2.
REQ-002 STARVE_LIMIT, default 15, stall count that raises starve; range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  4  per-channel valid for din0..din3; bit i qualifies din<i>.
REQ-006 din0..din3  input  `WIDTH_INTERNAL each  in-flight flits from the router input latches.
REQ-007 inj_valid  input  1  local injection request.
REQ-008 inj_flit  input  `WIDTH_INTERNAL  local flit to inject.
REQ-009 inj_ready  output  1  FIFO can accept a flit this cycle.
REQ-010 dout0..dout3  output  `WIDTH_INTERNAL each  registered flits to the permutation network.
REQ-011 out_valid  output  4  registered per-channel valid for dout0..dout3.
REQ-012 starve  output  1  injection-starvation flag.

Function
REQ-013 The age field SHALL be bits [`WIDTH_DATA+15:`WIDTH_DATA+8], an 8-bit unsigned value.
REQ-014 A push SHALL occur when inj_valid and inj_ready are both 1; inj_ready SHALL be !full, using the FIFO occupancy before any same-cycle pop.
REQ-015 A push with inj_valid=1 and inj_ready=0 SHALL be ignored, and FIFO contents SHALL be unchanged.
REQ-016 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-017 A flit pushed at edge N SHALL NOT be injected before edge N+1; no empty-FIFO bypass.
REQ-018 Each cycle, for every channel i with in_valid[i]=1, dout<i> SHALL receive din<i> with the age incremented by 1.
REQ-019 The age increment SHALL saturate at 255; all other fields SHALL pass unchanged.
REQ-020 Each cycle, for every channel with in_valid[i]=1, out_valid[i] SHALL be set to 1 at the next edge.
REQ-021 If the FIFO is non-empty and in_valid != 4'b1111, the head SHALL be popped into the lowest-indexed channel with in_valid=0.
REQ-022 On that injection, the channel's dout SHALL be the head flit with age forced to 0, and out_valid for that channel SHALL be 1.
REQ-023 At most one flit SHALL be injected per cycle.
REQ-024 A channel that is neither valid nor injected SHALL have out_valid=0, and its dout SHALL hold its previous value.
REQ-025 Latency: din to dout SHALL be exactly 1 cycle; FIFO head to dout SHALL be exactly 1 cycle.
REQ-026 Channel order SHALL be preserved (channel i in, channel i out); sorting belongs downstream.
REQ-027 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 FIFO occupancy SHALL range 0..FIFO_DEPTH, with full = (occupancy == FIFO_DEPTH).

Reset
REQ-029 While reset=1 at an edge, out_valid SHALL be set to 0 and dout0..dout3 SHALL be set to 0.
REQ-030 While reset=1 at an edge, the FIFO SHALL be emptied and the starvation counter cleared.
REQ-031 inj_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.
REQ-032 starve SHALL be 0 after reset.
REQ-033 Reset mid-operation SHALL discard all queued and in-flight flits, with no partial injection.

Configuration
REQ-034 Macro INJ_STARVE_EN SHALL compile the starvation monitor in or out.
REQ-035 With INJ_STARVE_EN defined, an 8-bit counter SHALL increment each cycle the FIFO is non-empty and in_valid=4'b1111.
REQ-036 With INJ_STARVE_EN defined, the counter SHALL clear on any injection or when the FIFO is empty.
REQ-037 With INJ_STARVE_EN defined, starve SHALL be registered and equal 1 while counter >= STARVE_LIMIT.
REQ-038 With INJ_STARVE_EN defined, the counter SHALL saturate at STARVE_LIMIT.
REQ-039 Without INJ_STARVE_EN, starve SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-040 Reset, then in_valid=4'b1111 with ages 15,14,13,12 -> next cycle out_valid=4'b1111, ages 16,15,14,13, data A,B,C,D unchanged.
REQ-041 Input age 255 on channel 2 -> dout2 age 255 (saturation), other fields unchanged.
REQ-042 Push flit E at edge N with in_valid=4'b0101 -> after edge N+1, dout1=E, age 0, out_valid=4'b0111.
REQ-043 With in_valid=4'b1111, push 5 flits back-to-back (FIFO_DEPTH=4) -> first 4 accepted, inj_ready=0 on the 5th, 5th flit dropped.
REQ-044 Same FIFO, then in_valid=4'b0000 for 4 cycles -> 4 flits emerge in push order on dout0, one per cycle, each with age 0.
REQ-045 INJ_STARVE_EN, STARVE_LIMIT=15, one flit queued, in_valid=4'b1111 held -> starve=1 after 15 stalled cycles, back to 0 the cycle after in_valid=4'b1110 allows injection.
REQ-046 Assert reset with 3 queued flits -> out_valid=0, inj_ready=0 during reset, FIFO empty afterward, no stale flit on dout.

Source files
------------

// File: rtl/inject_ctrl.sv
// inject_ctrl: ages in-flight flits by one cycle and injects queued local
// flits into the lowest free channel of a 4-channel router stage.
// Optional starvation monitor compiled in with INJ_STARVE_EN.
// Flit layout: age field at [`WIDTH_DATA+15:`WIDTH_DATA+8].

`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif
`ifndef WIDTH_INTERNAL
`define WIDTH_INTERNAL (`WIDTH_DATA + 16)
`endif

module inject_ctrl #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 in_valid,
  input  logic [`WIDTH_INTERNAL-1:0] din0,
  input  logic [`WIDTH_INTERNAL-1:0] din1,
  input  logic [`WIDTH_INTERNAL-1:0] din2,
  input  logic [`WIDTH_INTERNAL-1:0] din3,
  input  logic                       inj_valid,
  input  logic [`WIDTH_INTERNAL-1:0] inj_flit,
  output logic                       inj_ready,
  output logic [`WIDTH_INTERNAL-1:0] dout0,
  output logic [`WIDTH_INTERNAL-1:0] dout1,
  output logic [`WIDTH_INTERNAL-1:0] dout2,
  output logic [`WIDTH_INTERNAL-1:0] dout3,
  output logic [3:0]                 out_valid,
  output logic                       starve
);

  localparam int unsigned W      = `WIDTH_INTERNAL;
  localparam int unsigned AGE_LO = `WIDTH_DATA + 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;
  logic [3:0]       sel;
  logic             found;
  logic [W-1:0]     din_a  [4];
  logic [W-1:0]     dout_q [4];
  logic [W-1:0]     head;

  // Age +1 saturating at 255; other fields untouched.
  function automatic logic [W-1:0] age_inc(input logic [W-1:0] f);
    logic [W-1:0] r;
    r = f;
    if (f[AGE_LO +: 8] != 8'hFF) r[AGE_LO +: 8] = f[AGE_LO +: 8] + 8'd1;
    return r;
  endfunction

  // Freshly injected flits start with age 0.
  function automatic logic [W-1:0] age_clr(input logic [W-1:0] f);
    logic [W-1:0] r;
    r = f;
    r[AGE_LO +: 8] = 8'd0;
    return r;
  endfunction

  assign din_a[0] = din0;
  assign din_a[1] = din1;
  assign din_a[2] = din2;
  assign din_a[3] = din3;
  assign dout0 = dout_q[0];
  assign dout1 = dout_q[1];
  assign dout2 = dout_q[2];
  assign dout3 = dout_q[3];

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  // Readiness uses pre-pop occupancy so a full FIFO never accepts, even while draining.
  assign inj_ready = !full && !reset;
  assign push      = inj_valid && inj_ready;

  // Pick the lowest-indexed idle channel for the FIFO head.
  always_comb begin
    sel   = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!empty && !in_valid[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign pop = found;

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= inj_flit;
  end

  // Channel output registers and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) dout_q[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i])  dout_q[i] <= age_inc(din_a[i]);
        else if (sel[i])  dout_q[i] <= age_clr(head);
      end
      out_valid <= in_valid | sel;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef INJ_STARVE_EN
  logic [7:0] starve_cnt, cnt_next;

  // Count stalled cycles of a non-empty FIFO, saturating at the limit.
  always_comb begin
    cnt_next = starve_cnt;
    if (empty || pop) begin
      cnt_next = 8'd0;
    end else if (in_valid == 4'b1111 && starve_cnt < 8'(STARVE_LIMIT)) begin
      cnt_next = starve_cnt + 8'd1;
    end
  end

  // Flag tracks the counter value it will hold after this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 8'd0;
      starve     <= 1'b0;
    end else begin
      starve_cnt <= cnt_next;
      starve     <= (cnt_next >= 8'(STARVE_LIMIT));
    end
  end
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_inject_ctrl.sv
// Randomized bench for inject_ctrl with a queue-based reference model.

`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif
`ifndef WIDTH_INTERNAL
`define WIDTH_INTERNAL (`WIDTH_DATA + 16)
`endif

module tb_inject_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 15;
  localparam int unsigned W     = `WIDTH_INTERNAL;
  localparam int unsigned AL    = `WIDTH_DATA + 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_valid;
  logic [W-1:0] din [4];
  logic         inj_valid;
  logic [W-1:0] inj_flit;
  logic         inj_ready;
  logic [W-1:0] dout [4];
  logic [3:0]   out_valid;
  logic         starve;

  inject_ctrl #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
    .dout0(dout[0]), .dout1(dout[1]), .dout2(dout[2]), .dout3(dout[3]),
    .out_valid(out_valid), .starve(starve)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] q [$];
  logic [W-1:0] m_dout [4];
  logic [3:0]   m_ov;
  int           m_cnt;
  logic         m_starve;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] set_age(input logic [W-1:0] f, input int a);
    logic [W-1:0] r;
    r = f;
    r[AL +: 8] = 8'(a);
    return r;
  endfunction

  function automatic int age_of(input logic [W-1:0] f);
    return int'(f[AL +: 8]);
  endfunction

  function automatic logic [W-1:0] rnd_flit(input int age);
    logic [W-1:0] r;
    r = W'({$urandom, $urandom});
    return set_age(r, age);
  endfunction

  // One clock: check readiness, advance the model, compare registered outputs.
  task automatic tick();
    int  ch;
    bit  do_push;
    #1;
    chk("inj_ready", 64'(inj_ready), 64'(!reset && q.size() < DEPTH));
    if (reset) begin
      q.delete();
      for (int i = 0; i < 4; i++) m_dout[i] = '0;
      m_ov     = 4'b0000;
      m_cnt    = 0;
      m_starve = 1'b0;
    end else begin
      ch = -1;
      if (q.size() > 0)
        for (int i = 0; i < 4; i++) if (!in_valid[i] && ch < 0) ch = i;
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i])
          m_dout[i] = set_age(din[i], (age_of(din[i]) >= 255) ? 255 : age_of(din[i]) + 1);
        else if (i == ch)
          m_dout[i] = set_age(q[0], 0);
      end
      m_ov = in_valid;
      if (ch >= 0) m_ov[ch] = 1'b1;
`ifdef INJ_STARVE_EN
      if (q.size() == 0 || ch >= 0) m_cnt = 0;
      else if (in_valid == 4'b1111 && m_cnt < int'(LIMIT)) m_cnt++;
      m_starve = (m_cnt >= int'(LIMIT));
`else
      m_starve = 1'b0;
`endif
      do_push = inj_valid && (q.size() < DEPTH);
      if (ch >= 0) void'(q.pop_front());
      if (do_push) q.push_back(inj_flit);
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    for (int i = 0; i < 4; i++) chk($sformatf("dout%0d", i), 64'(dout[i]), 64'(m_dout[i]));
    chk("starve", 64'(starve), 64'(m_starve));
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid  = 4'b0000;
    inj_valid = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = rnd_flit(0);
    inj_flit = rnd_flit(0);
  endtask

  logic [W-1:0] e_flit;
  logic [W-1:0] pushed [5];

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // All channels busy, ages 15..12
    for (int i = 0; i < 4; i++) din[i] = rnd_flit(15 - i);
    in_valid = 4'b1111;
    tick();
    for (int i = 0; i < 4; i++) chk($sformatf("age_inc%0d", i), 64'(age_of(dout[i])), 64'(16 - i));

    // Age saturation on channel 2
    din[2] = rnd_flit(255);
    tick();
    chk("age_sat", 64'(age_of(dout[2])), 64'd255);

    // Injection into lowest free channel, one cycle after push
    idle();
    e_flit    = rnd_flit(77);
    inj_flit  = e_flit;
    inj_valid = 1'b1;
    in_valid  = 4'b0101;
    tick();
    chk("no_bypass", 64'(out_valid), 64'(4'b0101));
    inj_valid = 1'b0;
    tick();
    chk("inj_ch1", 64'(dout[1]), 64'(set_age(e_flit, 0)));
    chk("inj_ov", 64'(out_valid), 64'(4'b0111));

    // Fill FIFO with all channels busy; fifth push dropped
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      pushed[k] = rnd_flit(k + 3);
      inj_flit  = pushed[k];
      inj_valid = 1'b1;
      if (k == 4) begin
        #1;
        chk("full_ready", 64'(inj_ready), 64'd0);
        #(-0);
      end
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("drain%0d", k), 64'(dout[0]), 64'(set_age(pushed[k], 0)));
    end

    // Starvation: one queued flit, all channels busy
    in_valid  = 4'b1111;
    inj_valid = 1'b1;
    inj_flit  = rnd_flit(9);
    tick();
    inj_valid = 1'b0;
    for (int k = 0; k < int'(LIMIT); k++) tick();
`ifdef INJ_STARVE_EN
    chk("starve_set", 64'(starve), 64'd1);
`else
    chk("starve_off", 64'(starve), 64'd0);
`endif
    in_valid = 4'b1110;
    tick();
    chk("starve_clr", 64'(starve), 64'd0);
    chk("starve_inj", 64'(out_valid), 64'(4'b1111));

    // Reset with three queued flits
    in_valid  = 4'b1111;
    inj_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inj_flit = rnd_flit(k);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("rst_ov", 64'(out_valid), 64'd0);
    reset = 1'b0;
    idle();
    tick();
    chk("rst_empty", 64'(out_valid), 64'd0);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 1500; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
      inj_valid = 1'($urandom);
      inj_flit  = rnd_flit($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0:       din[i] = rnd_flit(255);
          1:       din[i] = rnd_flit(254);
          default: din[i] = rnd_flit($urandom_range(0, 253));
        endcase
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
